// File: rtl/pipo_pkg.sv
// Shared constants and helpers for the pipo staging register.
// Parity helper zero-extends to a fixed maximum width; XOR is unaffected by zero padding.
package pipo_pkg;

    localparam int PIPO_DEFAULT_WIDTH = 4;
    localparam int PIPO_DEFAULT_DEPTH = 1;
    localparam int PIPO_PARITY_MAX_W  = 256;

    function automatic logic pipo_parity(input logic [PIPO_PARITY_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/pipo_if.sv
// Parallel data bus for pipo: X in, Q/q_valid (and q_parity under PIPO_PARITY_EN) out.
// master drives X and observes outputs; slave is the register chain.
interface pipo_if
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Q;
    logic             q_valid;
`ifdef PIPO_PARITY_EN
    logic             q_parity;
`endif

    modport master (
        output X,
        input  Q,
        input  q_valid
`ifdef PIPO_PARITY_EN
        ,
        input  q_parity
`endif
    );

    modport slave (
        input  X,
        output Q,
        output q_valid
`ifdef PIPO_PARITY_EN
        ,
        output q_parity
`endif
    );

endinterface

// File: rtl/pipo_stage.sv
// One WIDTH-bit pipeline register with synchronous active-low clear.
// Latency: 1 cycle. Backpressure: none, captures every rising edge.
// Reset has priority over capture.
module pipo_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipo.sv
// Parallel-in parallel-out retiming chain of DEPTH stages; optional q_parity with PIPO_PARITY_EN.
// Latency: DEPTH cycles X->Q, one word per cycle. q_valid after DEPTH post-reset edges.
// Backpressure: none; samples every rising edge, no enable or hold.
module pipo
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_DEFAULT_WIDTH,
    parameter int DEPTH = PIPO_DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    pipo_if.slave  bus
);

    localparam int             CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    assign stage_d[0] = bus.X;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i > 0) begin : g_link
            assign stage_d[i] = stage_q[i-1];
        end
        pipo_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (stage_d[i]),
            .q_o   (stage_q[i])
        );
    end

    assign bus.Q = stage_q[DEPTH-1];

    // Fill counter saturates at DEPTH; valid is registered alongside it.
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             valid_q, valid_d;

    always_comb begin
        fill_d = fill_q;
        if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
        end
        valid_d = (fill_d == FILL_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    assign bus.q_valid = valid_q;

`ifdef PIPO_PARITY_EN
    // Parity of the word entering the last stage, so it lands in the same cycle as Q.
    logic parity_q, parity_d;

    assign parity_d = pipo_parity(PIPO_PARITY_MAX_W'(stage_d[DEPTH-1]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.q_parity = parity_q;
`endif

endmodule

// File: tb/tb_pipo.sv
// Directed checks of pipo at DEPTH 1/3 plus random width sweep at WIDTH 1 and 32.
// Parity checks are compiled in with PIPO_PARITY_EN.
module tb_pipo;

    logic clk;
    logic rst1_n, rst3_n, rstw_n;

    int n_tests = 0;
    int n_fail  = 0;

    pipo_if #(.WIDTH(4))  if1  ();
    pipo_if #(.WIDTH(4))  if3  ();
    pipo_if #(.WIDTH(1))  ifw1 ();
    pipo_if #(.WIDTH(32)) ifw32();

    pipo #(.WIDTH(4),  .DEPTH(1)) u_d1  (.clk(clk), .rst_n(rst1_n), .bus(if1));
    pipo #(.WIDTH(4),  .DEPTH(3)) u_d3  (.clk(clk), .rst_n(rst3_n), .bus(if3));
    pipo #(.WIDTH(1),  .DEPTH(2)) u_w1  (.clk(clk), .rst_n(rstw_n), .bus(ifw1));
    pipo #(.WIDTH(32), .DEPTH(4)) u_w32 (.clk(clk), .rst_n(rstw_n), .bus(ifw32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        hist1  [2];
    logic [31:0] hist32 [4];
    int          fill_w;

    initial begin
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        rstw_n = 1'b0;
        if1.X   = 4'b1111;
        if3.X   = 4'b1111;
        ifw1.X  = 1'b1;
        ifw32.X = 32'hffff_ffff;

        // Reset held for two edges with all-ones input
        step();
        step();
        check_eq("rst_d1_q",     32'(if1.Q),       32'h0);
        check_eq("rst_d1_valid", 32'(if1.q_valid), 32'h0);
        check_eq("rst_d3_q",     32'(if3.Q),       32'h0);
        check_eq("rst_d3_valid", 32'(if3.q_valid), 32'h0);
        check_eq("rst_w1_q",     32'(ifw1.Q),      32'h0);
        check_eq("rst_w32_q",    ifw32.Q,          32'h0);
`ifdef PIPO_PARITY_EN
        check_eq("rst_d1_par",   32'(if1.q_parity), 32'h0);
        check_eq("rst_d3_par",   32'(if3.q_parity), 32'h0);
`endif

        // Streaming, DEPTH 1
        rst1_n = 1'b1;
        if1.X = 4'b0101;
        step();
        check_eq("d1_q0",     32'(if1.Q),       32'h5);
        check_eq("d1_valid0", 32'(if1.q_valid), 32'h1);
        if1.X = 4'b0111;
        step();
        check_eq("d1_q1",     32'(if1.Q),       32'h7);
`ifdef PIPO_PARITY_EN
        check_eq("d1_par1",   32'(if1.q_parity), 32'h1);
`endif
        if1.X = 4'b1100;
        step();
        check_eq("d1_q2",     32'(if1.Q),       32'hc);
        check_eq("d1_valid2", 32'(if1.q_valid), 32'h1);
`ifdef PIPO_PARITY_EN
        check_eq("d1_par2",   32'(if1.q_parity), 32'h0);
`endif

        // Latency, DEPTH 3
        rst3_n = 1'b1;
        if3.X = 4'b0001;
        step();
        check_eq("d3_e1_q",     32'(if3.Q),       32'h0);
        check_eq("d3_e1_valid", 32'(if3.q_valid), 32'h0);
        if3.X = 4'b0010;
        step();
        check_eq("d3_e2_q",     32'(if3.Q),       32'h0);
        check_eq("d3_e2_valid", 32'(if3.q_valid), 32'h0);
        if3.X = 4'b0100;
        step();
        check_eq("d3_e3_q",     32'(if3.Q),       32'h1);
        check_eq("d3_e3_valid", 32'(if3.q_valid), 32'h1);
        if3.X = 4'b1000;
        step();
        check_eq("d3_e4_q",     32'(if3.Q),       32'h2);
        if3.X = 4'b0000;
        step();
        check_eq("d3_e5_q",     32'(if3.Q),       32'h4);
        step();
        check_eq("d3_e6_q",     32'(if3.Q),       32'h8);
        check_eq("d3_e6_valid", 32'(if3.q_valid), 32'h1);

        // Mid-stream reset, DEPTH 3: in-flight 1010/1011 must be discarded
        if3.X = 4'b1010;
        step();
        if3.X = 4'b1011;
        step();
        rst3_n = 1'b0;
        if3.X = 4'b1111;
        step();
        check_eq("mid_rst_q",     32'(if3.Q),       32'h0);
        check_eq("mid_rst_valid", 32'(if3.q_valid), 32'h0);
        rst3_n = 1'b1;
        if3.X = 4'b0011;
        step();
        check_eq("mid_r1_q",     32'(if3.Q),       32'h0);
        check_eq("mid_r1_valid", 32'(if3.q_valid), 32'h0);
        if3.X = 4'b0000;
        step();
        check_eq("mid_r2_q",     32'(if3.Q),       32'h0);
        check_eq("mid_r2_valid", 32'(if3.q_valid), 32'h0);
        step();
        check_eq("mid_r3_q",     32'(if3.Q),       32'h3);
        check_eq("mid_r3_valid", 32'(if3.q_valid), 32'h1);

        // Width sweep with a shift-history model
        for (int i = 0; i < 2; i++) hist1[i] = 1'b0;
        for (int i = 0; i < 4; i++) hist32[i] = 32'h0;
        fill_w = 0;
        rstw_n = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            ifw1.X  = 1'($urandom);
            ifw32.X = $urandom;
            step();
            hist1[1] = hist1[0];
            hist1[0] = ifw1.X;
            for (int k = 3; k > 0; k--) hist32[k] = hist32[k-1];
            hist32[0] = ifw32.X;
            fill_w++;
            check_eq("w1_q",      32'(ifw1.Q),         32'(hist1[1]));
            check_eq("w32_q",     ifw32.Q,             hist32[3]);
            check_eq("w1_valid",  32'(ifw1.q_valid),   32'(fill_w >= 2));
            check_eq("w32_valid", 32'(ifw32.q_valid),  32'(fill_w >= 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
